// File: rtl/uart_resp_tx.sv
// UART response transmitter: sends a 1-3 byte response word as back-to-back
// 8N1 frames, most significant byte first, with its own baud timing.
module uart_resp_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_resp,
  input  logic [23:0] resp,
  input  logic [1:0]  num_bytes,
  output logic        TX,
  output logic        tx_busy,
  output logic        resp_sent
);

  // state | meaning
  // IDLE  | line high, waiting for a request
  // START | start bit (low) of the current byte
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (high); then next byte or done
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  state_t          r_state;
  logic [CW-1:0]   r_baud_cnt;
  logic [2:0]      r_bit_cnt;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_shift;
  logic            r_tx;
  logic            r_busy;
  logic            r_sent;

  state_t          w_state_d;
  logic [CW-1:0]   w_baud_d;
  logic [2:0]      w_bit_d;
  logic [1:0]      w_byte_d;
  logic [23:0]     w_shift_d;
  logic [7:0]      w_cur_byte;
  logic            w_baud_done;
  logic            w_tx_d;
  logic            w_busy_d;
  logic            w_sent_d;

  assign w_baud_done = (r_baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_sent     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_baud_cnt <= w_baud_d;
      r_bit_cnt  <= w_bit_d;
      r_byte_cnt <= w_byte_d;
      r_shift    <= w_shift_d;
      r_tx       <= w_tx_d;
      r_busy     <= w_busy_d;
      r_sent     <= w_sent_d;
    end
  end

  // The byte on the wire always sits in r_shift[23:16]; shorter responses
  // are left-aligned at acceptance so the same path serves every length.
  always_comb begin
    w_state_d = r_state;
    w_baud_d  = w_baud_done ? '0 : r_baud_cnt + CW'(1);
    w_bit_d   = r_bit_cnt;
    w_byte_d  = r_byte_cnt;
    w_shift_d = r_shift;
    case (r_state)
      IDLE: begin
        w_baud_d = '0;
        if (snd_resp) begin
          w_state_d = START;
          w_bit_d   = '0;
          case (num_bytes)
            2'd3: begin
              w_shift_d = resp;
              w_byte_d  = 2'd2;
            end
            2'd2: begin
              w_shift_d = {resp[15:0], 8'h00};
              w_byte_d  = 2'd1;
            end
            default: begin
              w_shift_d = {resp[7:0], 16'h0000};
              w_byte_d  = 2'd0;
            end
          endcase
        end
      end
      START: begin
        if (w_baud_done) begin
          w_state_d = DATA;
          w_bit_d   = '0;
        end
      end
      DATA: begin
        if (w_baud_done) begin
          if (r_bit_cnt == 3'd7) w_state_d = STOP;
          else                   w_bit_d   = r_bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          if (r_byte_cnt != 2'd0) begin
            w_state_d = START;
            w_byte_d  = r_byte_cnt - 2'd1;
            w_shift_d = {r_shift[15:0], 8'h00};
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the upcoming state.
  always_comb begin
    w_cur_byte = w_shift_d[23:16];
    w_tx_d     = 1'b1;
    w_busy_d   = (w_state_d != IDLE);
    w_sent_d   = (r_state == STOP) && w_baud_done && (r_byte_cnt == 2'd0);
    case (w_state_d)
      START:   w_tx_d = 1'b0;
      DATA:    w_tx_d = w_cur_byte[w_bit_d];
      default: w_tx_d = 1'b1;
    endcase
  end

  assign TX        = r_tx;
  assign tx_busy   = r_busy;
  assign resp_sent = r_sent;

endmodule
